// File: rtl/seg7_count_checker_pkg.sv
// Shared types and constants for the 7-segment count checker.
// Segment codes are stored active-low {g,f,e,d,c,b,a}.
package seg7_count_checker_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_ACQ    = 2'b01,
        ST_LOCKED = 2'b10,
        ST_UNUSED = 2'b11
    } state_e;

    localparam int ERR_W = 8;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;

    function automatic logic [6:0] seg_code(input logic [2:0] digit);
        logic [6:0] code;
        case (digit)
            3'd0:    code = SEG_0;
            3'd1:    code = SEG_1;
            3'd2:    code = SEG_2;
            3'd3:    code = SEG_3;
            3'd4:    code = SEG_4;
            3'd5:    code = SEG_5;
            3'd6:    code = SEG_6;
            default: code = SEG_7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_count_checker_decode.sv
// Combinational 7-segment pattern to {legal, digit}; zero latency, no backpressure.
// SEG7_ACTIVE_HIGH_EN selects active-high segments (inputs inverted before lookup).
module seg7_decode
    import seg7_count_checker_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       legal_o,
    output logic [2:0] digit_o
);

    logic [6:0] pat_low;

`ifdef SEG7_ACTIVE_HIGH_EN
    assign pat_low = ~pattern_i;
`else
    assign pat_low = pattern_i;
`endif

    always_comb begin
        legal_o = 1'b0;
        digit_o = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pat_low == seg_code(3'(i))) begin
                legal_o = 1'b1;
                digit_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_count_checker.sv
// Monitor for a mod-8 counter and its 7-segment drive: lock FSM, mismatch pulses, error count.
// All outputs registered, 1-cycle latency; SEG7_ACTIVE_HIGH_EN flips segment polarity in the decoder.
module seg7_count_checker
    import seg7_count_checker_pkg::*;
#(
    parameter int LOCK_LEN = 3,
    parameter int MISS_MAX = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             iValid,
    input  logic [2:0]       iQ,
    input  logic [6:0]       iDisplay,
    output logic [2:0]       oDigit,
    output logic             oDigitValid,
    output logic             oLocked,
    output logic             oMismatch,
    output logic [ERR_W-1:0] oErrCnt,
    output logic [1:0]       oState
);

    state_e           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       digit_q, digit_d;
    logic             dv_q, dv_d;
    logic             mis_q, mis_d;
    logic             locked_q;

    logic       legal;
    logic [2:0] dec_digit;
    logic       consistent;
    logic       good;

    seg7_decode u_decode (
        .pattern_i (iDisplay),
        .legal_o   (legal),
        .digit_o   (dec_digit)
    );

    assign consistent = legal && (dec_digit == iQ);
    assign good       = consistent && (iQ == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = err_q;
        digit_d = digit_q;
        dv_d    = dv_q;
        mis_d   = 1'b0;

        if (iValid) begin
            dv_d = legal;
            if (legal) begin
                digit_d = dec_digit;
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (iValid && consistent) begin
                    exp_d   = iQ + 3'd1;
                    run_d   = 4'd1;
                    state_d = (LOCK_LEN == 1) ? ST_LOCKED : ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (iValid) begin
                    if (good) begin
                        run_d = run_q + 4'd1;
                        exp_d = exp_q + 3'd1;
                        if (run_q + 4'd1 == 4'(LOCK_LEN)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        run_d   = 4'd0;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (iValid) begin
                    // Expected count flywheels through bad samples.
                    exp_d = exp_q + 3'd1;
                    if (good) begin
                        miss_d = 4'd0;
                    end else begin
                        mis_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (miss_q + 4'd1 == 4'(MISS_MAX)) begin
                            miss_d  = 4'd0;
                            run_d   = 4'd0;
                            state_d = ST_HUNT;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
            end
            default: begin
                run_d   = 4'd0;
                miss_d  = 4'd0;
                state_d = ST_HUNT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            exp_q    <= 3'd0;
            run_q    <= 4'd0;
            miss_q   <= 4'd0;
            err_q    <= '0;
            digit_q  <= 3'd0;
            dv_q     <= 1'b0;
            mis_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            run_q    <= run_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            digit_q  <= digit_d;
            dv_q     <= dv_d;
            mis_q    <= mis_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

    assign oDigit      = digit_q;
    assign oDigitValid = dv_q;
    assign oLocked     = locked_q;
    assign oMismatch   = mis_q;
    assign oErrCnt     = err_q;
    assign oState      = state_q;

endmodule
